dmem_arbiter: RTL

Single-port data-memory arbiter that shares one synchronous-read RAM port between the RISC-V CPU load/store path and the VGA pixel fetch path, replacing the dual-port data memory. The CPU side gets a request/ready handshake (stalls on contention). The VGA side gets a line-prefetch engine that streams a programmed address range into a small FIFO. The VGA path has urgency priority when the FIFO runs low, bounded by a CPU starvation limit.

---
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data-memory arbiter between CPU load/store and VGA line prefetch
module dmem_arbiter #(
    parameter int FIFO_DEPTH = 8,
    parameter int LOW_WATER  = 2,
    parameter int MAX_WAIT   = 8
) (
    input  logic        sysclk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        line_start,
    input  logic [31:0] line_base,
    input  logic [9:0]  line_len,
    input  logic        vga_pop,
    output logic [31:0] vga_data,
    output logic        vga_empty,
    output logic        vga_underflow,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LOW_C   = CW'(LOW_WATER);
    localparam logic [WW-1:0] MAXW_C  = WW'(MAX_WAIT);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [31:0]     ptr_q, ptr_d;
    logic [9:0]      rem_q, rem_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_nxt;
    logic [WW-1:0]   wait_q, wait_d;
    logic            infl_q, discard_q;
    logic            cpu_ready_q, cpu_rd_q;
    logic            empty_q, empty_d;
    logic            underflow_q, underflow_d;
    logic [31:0]     head_q, head_d;
    logic [31:0]     fifo_q [FIFO_DEPTH];

    logic [CW-1:0]   level;
    logic            issuable, urgent, grant_cpu, grant_vga, push, pop_ok;

    // Level counts an in-flight read (even a discarded one) so the FIFO can never overfill.
    assign level     = count_q + CW'(infl_q);
    assign issuable  = (state_q == S_FETCH) && (level < DEPTH_C);
    assign urgent    = issuable && (level <= LOW_C);
    assign grant_cpu = reset_n && cpu_req && !cpu_ready_q && ((wait_q >= MAXW_C) || !urgent);
    assign grant_vga = reset_n && !grant_cpu && issuable;
    assign push      = infl_q && !discard_q && !line_start;
    assign pop_ok    = vga_pop && (count_q != '0) && !line_start;
    assign rd_nxt    = rd_ptr_q + AW'(1);

    assign mem_en    = grant_cpu || grant_vga;
    assign mem_we    = grant_cpu && cpu_we;
    assign mem_addr  = grant_cpu ? cpu_addr : (grant_vga ? ptr_q : 32'd0);
    assign mem_wdata = grant_cpu ? cpu_wdata : 32'd0;

    assign cpu_ready     = cpu_ready_q;
    assign cpu_rdata     = cpu_rd_q ? mem_rdata : 32'd0;
    assign vga_data      = head_q;
    assign vga_empty     = empty_q;
    assign vga_underflow = underflow_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        if (line_start) begin
            ptr_d   = line_base;
            rem_d   = line_len;
            state_d = (line_len != 10'd0) ? S_FETCH : S_IDLE;
        end else begin
            case (state_q)
                S_FETCH: if (grant_vga) begin
                    ptr_d = ptr_q + 32'd4;
                    rem_d = rem_q - 10'd1;
                    if (rem_q == 10'd1) state_d = S_DRAIN;
                end
                S_DRAIN: if (!infl_q) state_d = S_IDLE;
                default: ;
            endcase
        end
    end

    always_comb begin
        count_d     = line_start ? '0 : count_q + CW'(push) - CW'(pop_ok);
        empty_d     = (count_d == '0);
        wr_ptr_d    = line_start ? rd_ptr_q : wr_ptr_q + AW'(push);
        rd_ptr_d    = pop_ok ? rd_nxt : rd_ptr_q;
        underflow_d = line_start ? 1'b0 : (underflow_q || (vga_pop && count_q == '0));
        wait_d      = wait_q;
        if (!cpu_req || grant_cpu) wait_d = '0;
        else if (wait_q != MAXW_C) wait_d = wait_q + WW'(1);
        // Head only moves when a new word becomes the front; otherwise it holds the last value.
        head_d = head_q;
        if (pop_ok && count_q > CW'(1))
            head_d = fifo_q[rd_nxt];
        else if (push && (count_q == '0 || (pop_ok && count_q == CW'(1))))
            head_d = mem_rdata;
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            wait_q      <= '0;
            infl_q      <= 1'b0;
            discard_q   <= 1'b0;
            cpu_ready_q <= 1'b0;
            cpu_rd_q    <= 1'b0;
            empty_q     <= 1'b1;
            underflow_q <= 1'b0;
            head_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            wait_q      <= wait_d;
            infl_q      <= grant_vga;
            discard_q   <= grant_vga && line_start;
            cpu_ready_q <= grant_cpu;
            cpu_rd_q    <= grant_cpu && !cpu_we;
            empty_q     <= empty_d;
            underflow_q <= underflow_d;
            head_q      <= head_d;
        end
    end

    always_ff @(posedge sysclk) begin
        if (push) fifo_q[wr_ptr_q] <= mem_rdata;
    end
endmodule
